amstrad_mem_sched: RTL and testbench

//  Time-slot scheduler for the shared CPC video/CPU RAM port, locked to the 1 MHz phase of the gate array.

---
 rtl/amstrad_mem_pkg.sv | 24 ++
 rtl/amstrad_cpu_slot_fsm.sv | 90 +++++++++
 rtl/amstrad_mem_sched.sv | 132 +++++++++++++
 tb/tb_amstrad_mem_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/amstrad_mem_pkg.sv
// Shared types for the CPC RAM-port scheduler: slot phase, slot numbers, CPU FSM states.
package amstrad_mem_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t SLOT_VID0 = 2'd0;
  localparam phase_t SLOT_VID1 = 2'd1;
  localparam phase_t SLOT_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } cpu_state_t;

  // CRTC byte address: two high MA bits, three raster bits, ten low MA bits, byte select.
  function automatic logic [15:0] video_addr(input logic [13:0] ma,
                                             input logic [2:0]  ra,
                                             input logic        b);
    return {ma[13:12], ra, ma[9:0], b};
  endfunction

endpackage

// File: rtl/amstrad_cpu_slot_fsm.sv
// CPU side of the shared RAM port: latches a Z80 request, waits for its slot, returns ack/data.
module amstrad_cpu_slot_fsm
  import amstrad_mem_pkg::*;
#(
  parameter phase_t CPU_SLOT = 2'd2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE_4,
  input  phase_t      next_phase,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  mem_din,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic        cpu_wait,
  output logic        issue,
  output logic [15:0] acc_addr,
  output logic        acc_we,
  output logic [7:0]  acc_dout
);

  cpu_state_t  state_r;
  logic [15:0] addr_r;
  logic        we_r;
  logic [7:0]  dout_r;
  logic        abort_r;

  assign issue    = (state_r == PEND) & cpu_req & CE_4 & (next_phase == CPU_SLOT);
  assign cpu_wait = cpu_req & (state_r != DONE);
  assign acc_addr = addr_r;
  assign acc_we   = we_r;
  assign acc_dout = dout_r;

  // Request lifecycle; a request dropped during the RAM cycle still finishes but is not acked
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      addr_r  <= 16'd0;
      we_r    <= 1'b0;
      dout_r  <= 8'd0;
      abort_r <= 1'b0;
      cpu_din <= 8'd0;
      cpu_ack <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cpu_req) begin
            state_r <= PEND;
            addr_r  <= cpu_addr;
            we_r    <= cpu_we;
            dout_r  <= cpu_dout;
            abort_r <= 1'b0;
          end
        end
        PEND: begin
          if (!cpu_req) begin
            state_r <= IDLE;
          end else if (issue) begin
            state_r <= ACCESS;
          end
        end
        ACCESS: begin
          if (!cpu_req) begin
            abort_r <= 1'b1;
          end
          if (CE_4) begin
            state_r <= DONE;
            if (!we_r) begin
              cpu_din <= mem_din;
            end
            cpu_ack <= cpu_req & ~abort_r;
          end
        end
        DONE: begin
          if (!cpu_req) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/amstrad_mem_sched.sv
// Shared CPC RAM port scheduler: two video byte fetches and one CPU slot per 1 us frame,
// phase-locked to the gate array 1 MHz marker.
module amstrad_mem_sched
  import amstrad_mem_pkg::*;
#(
  parameter phase_t CPU_SLOT = 2'd2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE_4,
  input  logic        cyc1MHz,
  input  logic [13:0] crtc_ma,
  input  logic [4:0]  crtc_ra,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic        cpu_wait,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_vid,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic [15:0] vram_D
);

  phase_t      phase_r;
  phase_t      next_phase_s;
  logic [15:0] va0_s;
  logic [14:0] va_hi_r;
  logic [15:0] staging_r;
  logic        cpu_issue_s;
  logic [15:0] acc_addr_s;
  logic        acc_we_s;
  logic [7:0]  acc_dout_s;
  logic        unused_s;

  assign va0_s    = video_addr(crtc_ma, crtc_ra[2:0], 1'b0);
  assign unused_s = ^{crtc_ra[4:3], crtc_ma[11:10], va0_s[0]};

  // The GA marker forces slot 1 next, so the local count snaps back to the gate array each frame
  always_comb begin
    if (cyc1MHz) begin
      next_phase_s = SLOT_VID1;
    end else begin
      next_phase_s = phase_r + 2'd1;
    end
  end

  // Phase counter, CRTC address sampling, byte staging and the once-per-frame video word update
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase_r   <= SLOT_VID0;
      va_hi_r   <= 15'd0;
      staging_r <= 16'd0;
      vram_D    <= 16'd0;
    end else if (CE_4) begin
      phase_r <= next_phase_s;
      if (next_phase_s == SLOT_VID0) begin
        va_hi_r <= va0_s[15:1];
      end
      if (mem_vid) begin
        if (mem_addr[0]) begin
          staging_r[15:8] <= mem_din;
        end else begin
          staging_r[7:0] <= mem_din;
        end
      end
      if (phase_r == SLOT_LAST) begin
        vram_D <= staging_r;
      end
    end
  end

  // RAM port mux: video owns slots 0/1 unconditionally, the CPU gets its slot only when pending
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_addr <= 16'd0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_vid  <= 1'b0;
      mem_dout <= 8'd0;
    end else if (CE_4) begin
      if (next_phase_s == SLOT_VID0) begin
        mem_addr <= va0_s;
        mem_rd   <= 1'b1;
        mem_wr   <= 1'b0;
        mem_vid  <= 1'b1;
      end else if (next_phase_s == SLOT_VID1) begin
        mem_addr <= {va_hi_r, 1'b1};
        mem_rd   <= 1'b1;
        mem_wr   <= 1'b0;
        mem_vid  <= 1'b1;
      end else if (cpu_issue_s) begin
        mem_addr <= acc_addr_s;
        mem_rd   <= ~acc_we_s;
        mem_wr   <= acc_we_s;
        mem_vid  <= 1'b0;
        mem_dout <= acc_dout_s;
      end else begin
        mem_rd  <= 1'b0;
        mem_wr  <= 1'b0;
        mem_vid <= 1'b0;
      end
    end
  end

  amstrad_cpu_slot_fsm #(
    .CPU_SLOT (CPU_SLOT)
  ) u_cpu_fsm (
    .CLK        (CLK),
    .RESET      (RESET),
    .CE_4       (CE_4),
    .next_phase (next_phase_s),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .mem_din    (mem_din),
    .cpu_din    (cpu_din),
    .cpu_ack    (cpu_ack),
    .cpu_wait   (cpu_wait),
    .issue      (cpu_issue_s),
    .acc_addr   (acc_addr_s),
    .acc_we     (acc_we_s),
    .acc_dout   (acc_dout_s)
  );

endmodule

// File: tb/tb_amstrad_mem_sched.sv
// Directed bench for amstrad_mem_sched: video fetch table plus CPU/reset/phase-shift sequences.
module tb_amstrad_mem_sched;

  logic        CLK;
  logic        RESET;
  logic        CE_4;
  logic        cyc1MHz;
  logic [13:0] crtc_ma;
  logic [4:0]  crtc_ra;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_vid;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic [15:0] vram_D;

  int       checks = 0;
  int       errors = 0;
  int       sub_cnt;
  logic [1:0] ga_ph;
  bit       hold_ga;
  bit       ce_seen;

  typedef struct {
    logic [13:0] ma;
    logic [4:0]  ra;
    logic [15:0] addr0;
    logic [15:0] vram;
  } vid_vec_t;

  vid_vec_t vec [5];

  amstrad_mem_sched dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CE_4     (CE_4),
    .cyc1MHz  (cyc1MHz),
    .crtc_ma  (crtc_ma),
    .crtc_ra  (crtc_ra),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_ack  (cpu_ack),
    .cpu_wait (cpu_wait),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_vid  (mem_vid),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .vram_D   (vram_D)
  );

  // RAM model: returns the low address byte, except one marked location
  assign mem_din = (mem_addr == 16'h4000) ? 8'h5A : mem_addr[7:0];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One CLK; the bench gate array advances its phase on every CE_4 edge
  task automatic tick();
    @(posedge CLK);
    #1;
    ce_seen = CE_4;
    if (CE_4) begin
      if (hold_ga) hold_ga = 1'b0;
      else ga_ph = ga_ph + 2'd1;
    end
    sub_cnt = (sub_cnt + 1) % 4;
    CE_4    = (sub_cnt == 3);
    cyc1MHz = (ga_ph == 2'd0);
  endtask

  task automatic wait_ga(input logic [1:0] p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ce_seen && ga_ph == p) && n < 64);
    if (!(ce_seen && ga_ph == p)) begin
      checks++;
      errors++;
      $display("FAIL wait_ga: phase %0d not reached within %0d cycles", p, n);
    end
  endtask

  initial begin
    int wr_ticks, bad_slot, ack_ce, ce_n, cpu_strobes, acks, upd, bad_gap, last_upd, misalign;
    logic [15:0] wr_addr, rd_addr, prev_vram;
    logic [7:0]  wr_data;

    vec[0] = '{ma: 14'h3000, ra: 5'h02, addr0: 16'hD000, vram: 16'h0100};
    vec[1] = '{ma: 14'h0055, ra: 5'h00, addr0: 16'h00AA, vram: 16'hABAA};
    vec[2] = '{ma: 14'h1000, ra: 5'h00, addr0: 16'h4000, vram: 16'h015A};
    vec[3] = '{ma: 14'h3FFF, ra: 5'h1F, addr0: 16'hFFFE, vram: 16'hFFFE};
    vec[4] = '{ma: 14'h0C00, ra: 5'h18, addr0: 16'h0000, vram: 16'h0100};

    RESET = 1'b1; CE_4 = 1'b0; cyc1MHz = 1'b1; sub_cnt = 0; ga_ph = 2'd0; hold_ga = 1'b0;
    ce_seen = 1'b0; crtc_ma = 14'd0; crtc_ra = 5'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_dout = 8'd0;
    tick(); tick(); tick();
    chk("reset mem_rd", mem_rd, 1'b0);
    chk("reset mem_wr", mem_wr, 1'b0);
    chk("reset mem_vid", mem_vid, 1'b0);
    chk("reset mem_addr", mem_addr, 16'h0000);
    chk("reset vram_D", vram_D, 16'h0000);
    chk("reset cpu_ack", cpu_ack, 1'b0);
    chk("reset cpu_din", cpu_din, 8'h00);
    chk("reset cpu_wait", cpu_wait, 1'b0);
    RESET = 1'b0;
    wait_ga(2'd0);
    wait_ga(2'd0);

    // Video fetch table
    for (int i = 0; i < 5; i++) begin
      crtc_ma = vec[i].ma;
      crtc_ra = vec[i].ra;
      wait_ga(2'd0);
      chk($sformatf("v%0d slot0 addr", i), mem_addr, vec[i].addr0);
      chk($sformatf("v%0d slot0 vid/rd", i), {mem_vid, mem_rd, mem_wr}, 3'b110);
      wait_ga(2'd1);
      chk($sformatf("v%0d slot1 addr", i), mem_addr, vec[i].addr0 | 16'h0001);
      chk($sformatf("v%0d slot1 vid/rd", i), {mem_vid, mem_rd, mem_wr}, 3'b110);
      wait_ga(2'd2);
      chk($sformatf("v%0d slot2 idle", i), {mem_vid, mem_rd, mem_wr}, 3'b000);
      wait_ga(2'd0);
      chk($sformatf("v%0d vram_D", i), vram_D, vec[i].vram);
    end

    // CPU read raised at phase 0
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
    #1;
    chk("rd wait in request cycle", cpu_wait, 1'b1);
    wait_ga(2'd1);
    chk("rd slot1 still video", {mem_vid, cpu_ack, cpu_wait}, 3'b101);
    wait_ga(2'd2);
    chk("rd slot2 strobes", {mem_vid, mem_rd, mem_wr}, 3'b010);
    chk("rd slot2 addr", mem_addr, 16'h4000);
    wait_ga(2'd3);
    chk("rd ack", cpu_ack, 1'b1);
    chk("rd data", cpu_din, 8'h5A);
    chk("rd wait released", cpu_wait, 1'b0);
    chk("rd strobe dropped", mem_rd, 1'b0);
    tick();
    chk("rd ack one CLK", cpu_ack, 1'b0);
    wait_ga(2'd2);
    chk("rd held req not re-served", {mem_rd, mem_wr, cpu_ack}, 3'b000);
    cpu_req = 1'b0;
    tick();

    // CPU write raised exactly on the edge entering the CPU slot
    wait_ga(2'd1);
    for (int n = 0; n < 8 && !CE_4; n++) tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8001; cpu_dout = 8'hC3;
    wr_ticks = 0; bad_slot = 0; ack_ce = 0; ce_n = 0; wr_addr = 16'd0; wr_data = 8'd0;
    for (int n = 0; n < 64 && ack_ce == 0; n++) begin
      tick();
      if (ce_seen) ce_n++;
      if (n == 0) chk("wr missed slot no strobe", {mem_wr, cpu_wait}, 2'b01);
      if (mem_wr) begin
        wr_ticks++;
        wr_addr = mem_addr;
        wr_data = mem_dout;
        if (ga_ph <= 2'd1) bad_slot++;
      end
      if (cpu_ack) ack_ce = ce_n;
    end
    chk("wr ack CE_4 latency", ack_ce, 6);
    chk("wr strobe width", wr_ticks, 4);
    chk("wr never in video slot", bad_slot, 0);
    chk("wr addr", wr_addr, 16'h8001);
    chk("wr data", wr_data, 8'hC3);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // Request dropped while pending
    wait_ga(2'd3);
    cpu_req = 1'b1; cpu_addr = 16'h1111;
    tick(); tick();
    chk("abort wait while pending", cpu_wait, 1'b1);
    cpu_req = 1'b0;
    cpu_strobes = 0; acks = 0;
    for (int n = 0; n < 24; n++) begin
      tick();
      if ((mem_rd | mem_wr) & ~mem_vid) cpu_strobes++;
      if (cpu_ack) acks++;
    end
    chk("abort no RAM cycle", cpu_strobes, 0);
    chk("abort no ack", acks, 0);
    cpu_req = 1'b1; cpu_addr = 16'h2222;
    ack_ce = 0; rd_addr = 16'd0;
    for (int n = 0; n < 64 && ack_ce == 0; n++) begin
      tick();
      if (mem_rd & ~mem_vid) rd_addr = mem_addr;
      if (cpu_ack) ack_ce = 1;
    end
    chk("after abort new req acked", ack_ce, 1);
    chk("after abort new addr", rd_addr, 16'h2222);
    chk("after abort new data", cpu_din, 8'h22);
    cpu_req = 1'b0;
    tick();

    // Reset during a CPU access
    wait_ga(2'd0);
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    wait_ga(2'd2);
    chk("rst pre access", {mem_rd, mem_vid}, 2'b10);
    RESET = 1'b1;
    #2;
    chk("rst async strobes", {mem_rd, mem_wr, mem_vid, cpu_ack}, 4'b0000);
    chk("rst async addr", mem_addr, 16'h0000);
    chk("rst async vram_D", vram_D, 16'h0000);
    chk("rst async cpu_din", cpu_din, 8'h00);
    cpu_req = 1'b0;
    tick(); tick(); tick();
    RESET = 1'b0;
    wait_ga(2'd0);
    wait_ga(2'd0);
    chk("post rst slot0", {mem_vid, mem_rd}, 2'b11);
    chk("post rst slot0 addr", mem_addr, 16'h0000);
    wait_ga(2'd0);
    chk("post rst vram_D", vram_D, 16'h0100);

    // Gate array marker slips by one CE_4
    wait_ga(2'd1);
    hold_ga = 1'b1;
    upd = 0; bad_gap = 0; last_upd = -100; ce_n = 0; prev_vram = vram_D;
    for (int n = 0; n < 128; n++) begin
      tick();
      if (ce_seen) begin
        ce_n++;
        crtc_ma = crtc_ma + 14'd1;
      end
      if (vram_D !== prev_vram) begin
        if (ce_n - last_upd < 4) bad_gap++;
        last_upd = ce_n;
        upd++;
        prev_vram = vram_D;
      end
    end
    chk("shift vram_D once per frame", bad_gap, 0);
    chk("shift vram_D keeps updating", (upd >= 6), 1'b1);
    misalign = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (mem_vid !== (ga_ph <= 2'd1)) misalign++;
    end
    chk("shift realigned video slots", misalign, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
